dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
Data-memory-side responder for the CPU MEM stage. It accepts one load/store request per transaction: byte address, funct3, and lane-replicated store data. It drives the DM SRAM: chip select, output enable, active-low byte write strobes and word address. It returns the raw 32-bit word (the CPU does the sign/zero extension) and stalls the pipeline through the multi-cycle access.

Parameters:
ADDR_W, 14, SRAM word-address width (mem_a = cpu_addr[ADDR_W+1:2])
RD_LAT, 1, cycles spent in RD_WAIT before mem_do is sampled (>=1)
WR_LAT, 1, cycles mem_web is held active in WR_WAIT (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cpu_req  input  1  request valid (load or store) from MEM stage
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  32  byte address (ALU result)
cpu_funct3  input  3  RISC-V load/store funct3
cpu_wdata  input  32  store data, already replicated across lanes
cpu_stall  output  1  freeze pipeline
cpu_rvalid  output  1  one-cycle pulse: transaction complete
cpu_rdata  output  32  raw word read (0 for stores/errors)
cpu_misalign  output  1  one-cycle pulse with cpu_rvalid on misaligned access
mem_cs  output  1  SRAM chip select
mem_oe  output  1  SRAM output enable
mem_web  output  4  active-low byte write enables, bit i = byte lane i
mem_a  output  ADDR_W  SRAM word address
mem_di  output  32  SRAM write data
mem_do  input  32  SRAM read data

Behaviour:
- Reset values: state IDLE, counter 0, cpu_stall 0, cpu_rvalid 0, cpu_rdata 0, cpu_misalign 0, mem_cs 0, mem_oe 0, mem_web 4'b1111, mem_a 0, mem_di 0.
- FSM states and transitions:
  - IDLE: on cpu_req, latch addr/funct3/we/wdata. Go to DONE if misaligned, else WR_WAIT if cpu_we, else RD_WAIT.
  - RD_WAIT: lasts RD_LAT cycles; on its last cycle mem_do is registered into cpu_rdata; then DONE.
  - WR_WAIT: lasts WR_LAT cycles; then DONE.
  - DONE: always returns to IDLE after one cycle.
- cpu_stall = (IDLE && cpu_req) || RD_WAIT || WR_WAIT. Stall is combinational in the accept cycle and low in DONE, which is the cycle the pipeline advances.
- DONE: cpu_rvalid = 1. cpu_rdata holds the captured word for a load, 0 for a store or error. cpu_misalign = 1 if the access was misaligned.
- Latency with defaults: load = accept + RD_LAT + DONE = 3 cycles (stall high 2 cycles). Store = 3 cycles likewise.
- Memory drive:
  - RD_WAIT: mem_cs=1, mem_oe=1, mem_web=1111.
  - WR_WAIT: mem_cs=1, mem_oe=0, mem_web=strobe, mem_di=latched wdata.
  - mem_a = latched word address in both wait states.
  - All other states: cs=0, oe=0, web=1111.
- Strobe (funct3[1:0]):
  - byte: lane addr[1:0] low (00->1110, 01->1101, 10->1011, 11->0111).
  - half: addr[1]=0 -> 1100, addr[1]=1 -> 0011.
  - word: 0000.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=00. No SRAM access, direct to DONE, stall one cycle.
- funct3 unsigned variants (100, 101) are treated as reads of the same size; a store with funct3[2]=1 is treated as misaligned/illegal.
- cpu_req is ignored outside IDLE; no queuing; DONE never accepts a new request. Back-to-back requests are separated by at least one IDLE cycle.
- Reset mid-operation: next cycle IDLE with reset values, and any in-flight write strobe deasserts immediately. No rvalid is produced for the aborted request.
- Counter width $clog2(max(RD_LAT,WR_LAT)+1); it resets to 0 on every state entry.

Decomposition:
- Package dm_pkg:
  - dm_state_e {IDLE, RD_WAIT, WR_WAIT, DONE}
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - WEB_NONE=4'b1111
- Sub-module dm_web_gen: combinational; inputs funct3, addr[1:0], we; outputs web[3:0] and misalign.

Test Plan:
- Load word: req we=0 addr=0x0000_0104 f3=010, mem_do=0xDEADBEEF -> mem_a=0x41, oe/cs high 1 cycle, rvalid pulse in cycle 3 with rdata=0xDEADBEEF, stall high cycles 1-2.
- Store byte: addr=0x0000_0203 f3=000 wdata=0x5A5A5A5A -> mem_web=0111 for 1 cycle, mem_di=0x5A5A5A5A, rvalid in cycle 3, rdata=0.
- Store half: addr=0x0000_0002 f3=001 wdata=0x12341234 -> web=0011. Same with addr 0x0 -> web=1100.
- Misaligned: load word addr=0x0000_0006 -> no cs, rvalid+misalign in cycle 2, stall high only in cycle 1.
- RD_LAT=3 build: load -> stall high 4 cycles, mem_do sampled in the 3rd RD_WAIT cycle.
- rst asserted in WR_WAIT -> next cycle web=1111, cs=0, no rvalid; a following load completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } dm_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WEB_NONE = 4'b1111;

    // Active-high lane mask for a naturally aligned access of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr);
        logic [3:0] mask;
        mask = 4'b0000;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001 << addr;
            F3_H, F3_HU: mask = addr[1] ? 4'b1100 : 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dm_web_gen.sv
// Byte write-strobe and alignment decode for one load/store request.
module dm_web_gen
    import dm_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    input  logic       we,
    output logic [3:0] web,
    output logic       misalign
);

    logic [3:0] mask;

    always_comb begin
        mask     = lane_mask(funct3, addr);
        misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: misalign = 1'b0;
            F3_H, F3_HU: misalign = addr[0];
            F3_W:        misalign = (addr != 2'b00);
            default:     misalign = 1'b1;
        endcase
        // Unsigned funct3 encodings have no store meaning.
        if (we && funct3[2]) begin
            misalign = 1'b1;
        end
        web = (we && !misalign) ? ~mask : WEB_NONE;
    end

endmodule

// File: rtl/dm_responder.sv
// MEM-stage responder: sequences one SRAM load/store per request and
// stalls the pipeline until the raw word (or completion) is returned.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [2:0]        cpu_funct3,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_misalign,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic [3:0]        mem_web,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_do
);

    localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LAT - 1);

    dm_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       gen_web;
    logic             gen_misalign;
    logic             unused_addr;

    assign unused_addr = ^cpu_addr[31:ADDR_W+2];

    dm_web_gen u_web_gen (
        .funct3   (cpu_funct3),
        .addr     (cpu_addr[1:0]),
        .we       (cpu_we),
        .web      (gen_web),
        .misalign (gen_misalign)
    );

    // Stall must rise in the accept cycle itself, so it cannot wait for a register.
    assign cpu_stall = ((state == IDLE) && cpu_req) || (state == RD_WAIT) || (state == WR_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cpu_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            cpu_misalign <= 1'b0;
            mem_cs       <= 1'b0;
            mem_oe       <= 1'b0;
            mem_web      <= WEB_NONE;
            mem_a        <= '0;
            mem_di       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        cnt       <= '0;
                        cpu_rdata <= '0;
                        if (gen_misalign) begin
                            state        <= DONE;
                            cpu_rvalid   <= 1'b1;
                            cpu_misalign <= 1'b1;
                        end else if (cpu_we) begin
                            state   <= WR_WAIT;
                            mem_cs  <= 1'b1;
                            mem_web <= gen_web;
                            mem_a   <= cpu_addr[ADDR_W+1:2];
                            mem_di  <= cpu_wdata;
                        end else begin
                            state  <= RD_WAIT;
                            mem_cs <= 1'b1;
                            mem_oe <= 1'b1;
                            mem_a  <= cpu_addr[ADDR_W+1:2];
                        end
                    end
                end

                RD_WAIT: begin
                    if (cnt == RD_LAST) begin
                        state      <= DONE;
                        cnt        <= '0;
                        cpu_rdata  <= mem_do;
                        cpu_rvalid <= 1'b1;
                        mem_cs     <= 1'b0;
                        mem_oe     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                WR_WAIT: begin
                    if (cnt == WR_LAST) begin
                        state      <= DONE;
                        cnt        <= '0;
                        cpu_rvalid <= 1'b1;
                        mem_cs     <= 1'b0;
                        mem_web    <= WEB_NONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    cpu_rvalid   <= 1'b0;
                    cpu_misalign <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: default build plus an RD_LAT=3 build.
module tb_dm_responder;
    import dm_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        req3;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_wdata;
    logic [31:0] mem_do;

    logic        cpu_stall, cpu_rvalid, cpu_misalign, mem_cs, mem_oe;
    logic [31:0] cpu_rdata, mem_di;
    logic [3:0]  mem_web;
    logic [13:0] mem_a;

    logic        stall3, rvalid3, misalign3, cs3, oe3;
    logic [31:0] rdata3, di3;
    logic [3:0]  web3;
    logic [13:0] a3;

    int   checks;
    int   failures;
    exp_t q[$];
    exp_t q3[$];
    exp_t mon_e;
    exp_t mon_e3;

    dm_responder dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_funct3(cpu_funct3), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_misalign(cpu_misalign),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web), .mem_a(mem_a),
        .mem_di(mem_di), .mem_do(mem_do)
    );

    dm_responder #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cpu_req(req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_funct3(cpu_funct3), .cpu_wdata(cpu_wdata), .cpu_stall(stall3),
        .cpu_rvalid(rvalid3), .cpu_rdata(rdata3), .cpu_misalign(misalign3),
        .mem_cs(cs3), .mem_oe(oe3), .mem_web(web3), .mem_a(a3),
        .mem_di(di3), .mem_do(mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitors: every rvalid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (q.size() == 0) begin
                check("unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("rdata", cpu_rdata, mon_e.rdata);
                check("misalign", 32'(cpu_misalign), 32'(mon_e.mis));
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid3) begin
            if (q3.size() == 0) begin
                check("unexpected_rvalid3", 32'(rvalid3), 32'd0);
            end else begin
                mon_e3 = q3.pop_front();
                check("rdata3", rdata3, mon_e3.rdata);
                check("misalign3", 32'(misalign3), 32'(mon_e3.mis));
            end
        end
    end

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wdata, input logic [3:0] exp_web,
                           input logic exp_mis, input logic [31:0] exp_rdata);
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_funct3 = f3;
        cpu_wdata  = wdata;
        q.push_back('{rdata: exp_rdata, mis: exp_mis});
        @(negedge clk);
        check("stall_accept", 32'(cpu_stall), 32'd1);
        check("cs_accept", 32'(mem_cs), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        if (!exp_mis) begin
            @(negedge clk);
            check("stall_wait", 32'(cpu_stall), 32'd1);
            check("cs_wait", 32'(mem_cs), 32'd1);
            check("oe_wait", 32'(mem_oe), 32'(!we));
            check("web_wait", 32'(mem_web), 32'(exp_web));
            check("a_wait", 32'(mem_a), 32'(addr[15:2]));
            if (we) check("di_wait", mem_di, wdata);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_done", 32'(cpu_stall), 32'd0);
        check("cs_done", 32'(mem_cs), 32'd0);
        check("web_done", 32'(mem_web), 32'hF);
        @(posedge clk); #1;
        check("rvalid_clear", 32'(cpu_rvalid), 32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        cpu_req    = 1'b0;
        req3       = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_funct3 = '0;
        cpu_wdata  = '0;
        mem_do     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_misalign", 32'(cpu_misalign), 32'd0);
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_oe", 32'(mem_oe), 32'd0);
        check("rst_web", 32'(mem_web), 32'hF);
        check("rst_a", 32'(mem_a), 32'd0);
        check("rst_di", mem_di, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        mem_do = 32'hDEADBEEF;
        run_txn(1'b0, 32'h0000_0104, F3_W,  32'h0,         4'hF,    1'b0, 32'hDEADBEEF);
        run_txn(1'b1, 32'h0000_0203, F3_B,  32'h5A5A5A5A,  4'b0111, 1'b0, 32'h0);
        run_txn(1'b1, 32'h0000_0002, F3_H,  32'h12341234,  4'b0011, 1'b0, 32'h0);
        run_txn(1'b1, 32'h0000_0000, F3_H,  32'h12341234,  4'b1100, 1'b0, 32'h0);
        run_txn(1'b1, 32'h0000_0010, F3_W,  32'hA5A50F0F,  4'b0000, 1'b0, 32'h0);
        run_txn(1'b1, 32'h0000_0001, F3_B,  32'h77777777,  4'b1101, 1'b0, 32'h0);
        run_txn(1'b0, 32'h0000_0006, F3_W,  32'h0,         4'hF,    1'b1, 32'h0);
        run_txn(1'b0, 32'h0000_0001, F3_HU, 32'h0,         4'hF,    1'b1, 32'h0);
        run_txn(1'b1, 32'h0000_0008, F3_BU, 32'h11111111,  4'hF,    1'b1, 32'h0);
        mem_do = 32'h11223344;
        run_txn(1'b0, 32'h0000_0007, F3_BU, 32'h0,         4'hF,    1'b0, 32'h11223344);

        // Reset while a write strobe is active: no completion may follow.
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h0000_0020;
        cpu_funct3 = F3_W;
        cpu_wdata  = 32'hCCCCCCCC;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("abort_web_active", 32'(mem_web), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_web", 32'(mem_web), 32'hF);
        check("abort_cs", 32'(mem_cs), 32'd0);
        check("abort_stall", 32'(cpu_stall), 32'd0);
        check("abort_rvalid", 32'(cpu_rvalid), 32'd0);
        @(posedge clk); #1;
        mem_do = 32'h0BADF00D;
        run_txn(1'b0, 32'h0000_0104, F3_W, 32'h0, 4'hF, 1'b0, 32'h0BADF00D);

        // RD_LAT=3 build: data must come from the third wait cycle.
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0000_0040;
        cpu_funct3 = F3_W;
        req3       = 1'b1;
        q3.push_back('{rdata: 32'hCAFEF00D, mis: 1'b0});
        @(negedge clk);
        check("l3_stall_accept", 32'(stall3), 32'd1);
        @(posedge clk); #1;
        req3   = 1'b0;
        mem_do = 32'hAAAA0001;
        @(negedge clk);
        check("l3_stall_w1", 32'(stall3), 32'd1);
        check("l3_cs_w1", 32'(cs3), 32'd1);
        @(posedge clk); #1;
        mem_do = 32'hAAAA0002;
        @(negedge clk);
        check("l3_stall_w2", 32'(stall3), 32'd1);
        check("l3_oe_w2", 32'(oe3), 32'd1);
        @(posedge clk); #1;
        mem_do = 32'hCAFEF00D;
        @(negedge clk);
        check("l3_stall_w3", 32'(stall3), 32'd1);
        check("l3_a_w3", 32'(a3), 32'h10);
        @(posedge clk); #1;
        mem_do = 32'h0;
        @(negedge clk);
        check("l3_stall_done", 32'(stall3), 32'd0);
        check("l3_rvalid_done", 32'(rvalid3), 32'd1);
        check("l3_cs_done", 32'(cs3), 32'd0);

        repeat (3) @(negedge clk);
        check("pending_default", 32'(q.size()), 32'd0);
        check("pending_lat3", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
